// File: rtl/wwvb_pkg.sv
// Shared symbol encodings, classifier states and default low-duration boundaries.
package wwvb_pkg;

  localparam int unsigned DUR_W = 16;

  // Default boundaries in samples at 1000 samples/s.
  localparam int unsigned DEF_LOW_MIN = 100;
  localparam int unsigned DEF_T01     = 350;
  localparam int unsigned DEF_T1M     = 650;
  localparam int unsigned DEF_LOW_MAX = 950;

  typedef enum logic [1:0] {
    SYM_ZERO   = 2'd0,
    SYM_ONE    = 2'd1,
    SYM_MARKER = 2'd2,
    SYM_ERROR  = 2'd3
  } symbol_t;

  typedef enum logic [1:0] {
    ST_HIGH      = 2'd0,
    ST_LOW       = 2'd1,
    ST_WAIT_HIGH = 2'd2
  } state_t;

  // Output word layout: {symbol[1:0], duration[15:0]}.
  typedef struct packed {
    symbol_t            symbol;
    logic [DUR_W-1:0]   duration;
  } symbol_word_t;

  // Map a completed low duration (already known to be >= LOW_MIN) to a symbol.
  function automatic symbol_t classify(input logic [DUR_W-1:0] dur,
                                       input logic [DUR_W-1:0] t01,
                                       input logic [DUR_W-1:0] t1m);
    symbol_t sym;
    if (dur < t01)      sym = SYM_ZERO;
    else if (dur < t1m) sym = SYM_ONE;
    else                sym = SYM_MARKER;
    return sym;
  endfunction

endpackage

// File: rtl/wwvb_envelope.sv
// Magnitude, envelope low-pass, decaying peak tracker and hysteresis low/high decision.
module wwvb_envelope
  import wwvb_pkg::*;
#(
  parameter int unsigned WIDTH       = 20,
  parameter int unsigned ALPHA_SHIFT = 4,
  parameter int unsigned DECAY_SHIFT = 10,
  parameter int unsigned MIN_PEAK    = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sample,
  input  logic             sample_valid,
  output logic             low,
  output logic             low_c
);

  localparam int unsigned EW = WIDTH + 1;

  logic [WIDTH-1:0]     neg;
  logic [WIDTH-1:0]     mag;
  logic signed [EW-1:0] mag_s;
  logic signed [EW-1:0] env;
  logic signed [EW-1:0] diff;
  logic signed [EW-1:0] env_next;
  logic [EW-1:0]        env_u;
  logic [EW-1:0]        peak;
  logic [EW-1:0]        peak_dec;
  logic [EW-1:0]        peak_next;
  logic [EW-1:0]        half;
  logic [EW-1:0]        upper;

  // Next envelope/peak and the hysteresis decision for the current sample.
  always_comb begin
    neg = ~sample + WIDTH'(1);
    if (!sample[WIDTH-1])  mag = sample;
    else if (neg[WIDTH-1]) mag = {1'b0, {(WIDTH-1){1'b1}}};
    else                   mag = neg;
    mag_s     = signed'({1'b0, mag});
    diff      = mag_s - env;
    env_next  = env + (diff >>> ALPHA_SHIFT);
    env_u     = unsigned'(env_next);
    peak_dec  = peak - (peak >> DECAY_SHIFT);
    peak_next = (env_u > peak_dec) ? env_u : peak_dec;
    half      = peak >> 1;
    upper     = half + (peak >> 3);
    low_c     = low;
    if (peak < EW'(MIN_PEAK)) low_c = 1'b0;
    else if (env_u < half)    low_c = 1'b1;
    else if (env_u > upper)   low_c = 1'b0;
  end

  // Envelope state advances only on accepted samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      env  <= '0;
      peak <= '0;
      low  <= 1'b0;
    end else if (sample_valid) begin
      env  <= env_next;
      peak <= peak_next;
      low  <= low_c;
    end
  end

endmodule

// File: rtl/wwvb_pulse_classifier.sv
// WWVB low-pulse width classifier: times carrier-low periods and emits ZERO/ONE/MARKER/ERROR.
module wwvb_pulse_classifier
  import wwvb_pkg::*;
#(
  parameter int unsigned WIDTH       = 20,
  parameter int unsigned ALPHA_SHIFT = 4,
  parameter int unsigned DECAY_SHIFT = 10,
  parameter int unsigned MIN_PEAK    = 64,
  parameter int unsigned LOW_MIN     = DEF_LOW_MIN,
  parameter int unsigned T01         = DEF_T01,
  parameter int unsigned T1M         = DEF_T1M,
  parameter int unsigned LOW_MAX     = DEF_LOW_MAX
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] input_tdata,
  input  logic             input_tvalid,
  output logic             input_tready,
  output logic [17:0]      output_tdata,
  output logic             output_tvalid,
  input  logic             output_tready,
  output logic             overflow,
  output logic             carrier_low
);

  state_t           state;
  state_t           state_next;
  logic [DUR_W-1:0] count;
  logic [DUR_W-1:0] count_next;
  logic             low_c;
  logic             emit_c;
  symbol_word_t     word_c;

  assign input_tready = 1'b1;

  wwvb_envelope #(
    .WIDTH       (WIDTH),
    .ALPHA_SHIFT (ALPHA_SHIFT),
    .DECAY_SHIFT (DECAY_SHIFT),
    .MIN_PEAK    (MIN_PEAK)
  ) u_envelope (
    .clk          (clk),
    .rst          (rst),
    .sample       (input_tdata),
    .sample_valid (input_tvalid),
    .low          (carrier_low),
    .low_c        (low_c)
  );

  // State and low-duration counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_HIGH;
      count <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  // Next state, counter and symbol emission, evaluated on accepted samples only.
  always_comb begin
    state_next = state;
    count_next = count;
    emit_c     = 1'b0;
    word_c     = '{symbol: SYM_ZERO, duration: count};
    if (input_tvalid) begin
      case (state)
        ST_HIGH: begin
          if (low_c) begin
            state_next = ST_LOW;
            count_next = DUR_W'(1);
          end
        end
        ST_LOW: begin
          if (low_c) begin
            count_next = (count == {DUR_W{1'b1}}) ? count : count + DUR_W'(1);
            if (count_next >= DUR_W'(LOW_MAX)) begin
              emit_c     = 1'b1;
              word_c     = '{symbol: SYM_ERROR, duration: DUR_W'(LOW_MAX)};
              state_next = ST_WAIT_HIGH;
            end
          end else begin
            state_next = ST_HIGH;
            if (count >= DUR_W'(LOW_MIN)) begin
              emit_c = 1'b1;
              word_c = '{symbol: classify(count, DUR_W'(T01), DUR_W'(T1M)), duration: count};
            end
          end
        end
        ST_WAIT_HIGH: begin
          if (!low_c) state_next = ST_HIGH;
        end
        default: state_next = ST_HIGH;
      endcase
    end
  end

  // One-entry output holding register; a symbol arriving while it is blocked is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      output_tdata  <= '0;
      output_tvalid <= 1'b0;
      overflow      <= 1'b0;
    end else if (emit_c && (!output_tvalid || output_tready)) begin
      output_tdata  <= word_c;
      output_tvalid <= 1'b1;
    end else if (emit_c) begin
      overflow      <= 1'b1;
    end else if (output_tvalid && output_tready) begin
      output_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wwvb_pulse_classifier.sv
// Randomized scoreboard bench for wwvb_pulse_classifier with an integer reference model.
module tb_wwvb_pulse_classifier;

  localparam int W = 20;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [W-1:0]  input_tdata = '0;
  logic          input_tvalid = 1'b0;
  logic          input_tready;
  logic [17:0]   output_tdata;
  logic          output_tvalid;
  logic          output_tready = 1'b1;
  logic          overflow;
  logic          carrier_low;

  wwvb_pulse_classifier dut (
    .clk           (clk),
    .rst           (rst),
    .input_tdata   (input_tdata),
    .input_tvalid  (input_tvalid),
    .input_tready  (input_tready),
    .output_tdata  (output_tdata),
    .output_tvalid (output_tvalid),
    .output_tready (output_tready),
    .overflow      (overflow),
    .carrier_low   (carrier_low)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit armed    = 1'b0;
  int rdy_mode = 0;
  bit rdy_state = 1'b1;

  logic [17:0] exp_q[$];
  logic [17:0] got_q[$];

  // Reference model state (values as of the most recent clock edge).
  longint m_env, m_peak;
  bit     m_low, m_dead, m_valid, m_ovf;
  int     m_run;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_env = 0; m_peak = 0; m_low = 0; m_dead = 0; m_valid = 0; m_ovf = 0; m_run = 0;
    exp_q.delete();
  endtask

  // Behaviour of one clock edge given the inputs presented before it.
  task automatic model_step(input bit v, input int x, input bit r);
    bit          emit;
    logic [17:0] e;
    longint      mag, diff, step, en, pd;
    int          sym;
    emit = 0; e = '0;
    if (v) begin
      mag = (x < 0) ? -longint'(x) : longint'(x);
      if (mag > 524287) mag = 524287;
      diff = mag - m_env;
      step = (diff >= 0) ? diff / 16 : -((-diff + 15) / 16);
      en   = m_env + step;
      pd   = m_peak - m_peak / 1024;
      if (m_peak < 64)                          m_low = 0;
      else if (en < m_peak / 2)                 m_low = 1;
      else if (en > m_peak / 2 + m_peak / 8)    m_low = 0;
      m_env  = en;
      m_peak = (en > pd) ? en : pd;
      if (m_low) begin
        if (!m_dead) begin
          if (m_run < 65535) m_run++;
          if (m_run >= 950) begin
            emit = 1; e = {2'd3, 16'd950}; m_dead = 1;
          end
        end
      end else begin
        if (!m_dead && m_run >= 100) begin
          sym  = (m_run < 350) ? 0 : (m_run < 650) ? 1 : 2;
          emit = 1; e = {2'(sym), 16'(m_run)};
        end
        m_run = 0; m_dead = 0;
      end
    end
    if (emit) begin
      if (!m_valid || r) begin
        exp_q.push_back(e);
        m_valid = 1;
      end else begin
        m_ovf = 1;
      end
    end else if (m_valid && r) begin
      m_valid = 0;
    end
  endtask

  task automatic check_state();
    chk("carrier_low", longint'(carrier_low), longint'(m_low));
    chk("output_tvalid", longint'(output_tvalid), longint'(m_valid));
    chk("overflow", longint'(overflow), longint'(m_ovf));
    chk("input_tready", longint'(input_tready), 1);
    if (m_valid && exp_q.size() > 0) chk("held_tdata", longint'(output_tdata), longint'(exp_q[0]));
  endtask

  function automatic bit rdy_bit();
    if (rdy_mode == 0) return 1'b1;
    if (rdy_mode == 2) return 1'b0;
    if ($urandom_range(599) == 0) rdy_state = ~rdy_state;
    return rdy_state;
  endfunction

  // amp < 0: near-zero noise; amp >= 2^19: full-scale including the most negative code.
  function automatic int gen(input int amp);
    int val;
    if (amp < 0) return int'($urandom_range(16)) - 8;
    if (amp == 0) return 0;
    if (amp >= 524288) return ($urandom_range(1) == 1) ? -524288 : 524287;
    val = amp - int'($urandom_range(amp / 50));
    return ($urandom_range(1) == 1) ? -val : val;
  endfunction

  task automatic tick(input bit v, input int x, input bit r);
    @(posedge clk); #1;
    if (armed) check_state();
    input_tvalid  = v;
    input_tdata   = W'(x);
    output_tready = r;
    model_step(v, x, r);
  endtask

  task automatic run_seg(input int n, input int amp);
    int acc;
    bit v;
    acc = 0;
    while (acc < n) begin
      v = ($urandom_range(7) != 0);
      tick(v, v ? gen(amp) : int'($urandom), rdy_bit());
      if (v) acc++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, int'($urandom), rdy_bit());
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    if (armed) check_state();
    rst = 1'b1; input_tvalid = 1'b0; output_tready = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tdata", longint'(output_tdata), 0);
    chk("rst_tvalid", longint'(output_tvalid), 0);
    chk("rst_overflow", longint'(overflow), 0);
    chk("rst_carrier_low", longint'(carrier_low), 0);
    rst = 1'b0;
    armed = 1'b1;
  endtask

  task automatic check_sym(input string name, input int idx, input int sym, input int lo, input int hi);
    int dur;
    checks++;
    if (idx >= got_q.size()) begin
      failures++;
      $display("FAIL %s missing_symbol delivered=%0d required_index=%0d", name, got_q.size(), idx);
    end else begin
      dur = int'(got_q[idx][15:0]);
      chk({name, "_symbol"}, longint'(got_q[idx][17:16]), sym);
      if (dur < lo || dur > hi) begin
        failures++;
        $display("FAIL %s_duration actual=%0d required=%0d..%0d", name, dur, lo, hi);
      end
    end
  endtask

  // Monitor: pops the scoreboard on every output handshake.
  initial begin : monitor
    logic [17:0] e;
    forever begin
      @(negedge clk);
      if (!rst && output_tvalid && output_tready) begin
        got_q.push_back(output_tdata);
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_symbol actual=%h required=none", output_tdata);
        end else begin
          e = exp_q.pop_front();
          if (e !== output_tdata) begin
            failures++;
            $display("FAIL symbol_word actual=%h required=%h", output_tdata, e);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    model_reset();
    do_reset();

    // Nominal 200-sample low -> ZERO.
    got_q.delete(); rdy_mode = 0;
    run_seg(2000, 1000); run_seg(200, 0); run_seg(300, 1000); idle(10);
    chk("zero_count", got_q.size(), 1);
    check_sym("zero", 0, 0, 180, 220);

    // 500 -> ONE, 800 -> MARKER.
    got_q.delete();
    run_seg(500, -1); run_seg(300, 1000); run_seg(800, -1); run_seg(300, 1000); idle(10);
    chk("one_marker_count", got_q.size(), 2);
    check_sym("one", 0, 1, 480, 520);
    check_sym("marker", 1, 2, 780, 820);

    // 50 glitch, then 1200 -> single ERROR(950).
    got_q.delete();
    run_seg(50, 0); run_seg(300, 1000); run_seg(1200, 0); run_seg(300, 1000); idle(10);
    chk("error_count", got_q.size(), 1);
    check_sym("error", 0, 3, 950, 950);

    // Backpressure across two pulses: first held, second dropped.
    got_q.delete(); rdy_mode = 2;
    run_seg(200, -1); run_seg(300, 1000); run_seg(500, -1); run_seg(300, 1000);
    @(negedge clk);
    chk("bp_overflow", longint'(overflow), 1);
    chk("bp_tvalid", longint'(output_tvalid), 1);
    chk("bp_symbol", longint'(output_tdata[17:16]), 0);
    rdy_mode = 0; idle(10);
    chk("bp_count", got_q.size(), 1);
    check_sym("bp_first", 0, 0, 180, 220);

    // Silence: no carrier, no symbols; then reset during a low.
    do_reset(); got_q.delete();
    run_seg(5000, 0);
    @(negedge clk);
    chk("silence_carrier_low", longint'(carrier_low), 0);
    chk("silence_count", got_q.size(), 0);
    run_seg(2000, 1000); run_seg(300, 0);
    do_reset();
    run_seg(500, 1000); idle(5);
    chk("midlow_reset_count", got_q.size(), 0);
    run_seg(200, 0); run_seg(300, 1000); idle(5);
    check_sym("post_reset", 0, 0, 180, 220);

    // Randomized pulse trains with bursty ready at several amplitudes.
    for (int k = 0; k < 3; k++) begin
      int amp;
      amp = (k == 0) ? 1000 : (k == 1) ? int'($urandom_range(30000, 2000)) : 524288;
      do_reset(); rdy_mode = 1; rdy_state = 1'b1;
      run_seg(1500, amp);
      for (int p = 0; p < 7; p++) begin
        run_seg(int'($urandom_range(1300, 20)), ($urandom_range(1) == 1) ? 0 : -1);
        run_seg(int'($urandom_range(500, 150)), amp);
      end
    end

    rdy_mode = 0; idle(20);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
